// File: rtl/quiz_countdown_timer_if.sv
// rtl/quiz_countdown_timer_if.sv - control and display bundle of the quiz countdown timer
// master drives load/start/pause/bonus; slave returns time, BCD digits and status.
interface quiz_countdown_timer_if #(
  parameter int MIN_W = 6,
  parameter int SEC_W = 6
);
  logic             load_i;
  logic [MIN_W-1:0] load_mins_i;
  logic [SEC_W-1:0] load_secs_i;
  logic             start_i;
  logic             pause_i;
  logic             bonus_i;
  logic [SEC_W-1:0] bonus_secs_i;
  logic [MIN_W-1:0] timer_mins;
  logic [SEC_W-1:0] timer_secs;
  logic [15:0]      hex_digits_o;
  logic [1:0]       state_o;
  logic             expired_o;
  logic             warn_o;
  logic             blank_o;

  modport master (
    output load_i, load_mins_i, load_secs_i, start_i, pause_i, bonus_i, bonus_secs_i,
    input  timer_mins, timer_secs, hex_digits_o, state_o, expired_o, warn_o, blank_o
  );

  modport slave (
    input  load_i, load_mins_i, load_secs_i, start_i, pause_i, bonus_i, bonus_secs_i,
    output timer_mins, timer_secs, hex_digits_o, state_o, expired_o, warn_o, blank_o
  );
endinterface

// File: rtl/quiz_countdown_timer.sv
// rtl/quiz_countdown_timer.sv - mm:ss quiz countdown with pause, saturating bonus and low-time warning
// Optional display blink on warning: define QUIZ_TIMER_WARN_BLINK_EN.
module quiz_countdown_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int MIN_W     = 6,
  parameter int SEC_W     = 6,
  parameter int MAX_MINS  = 59,
  parameter int WARN_SECS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  quiz_countdown_timer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] C59    = SEC_W'(59);
  localparam logic [SEC_W:0]   C60    = (SEC_W + 1)'(60);
  localparam logic [MIN_W-1:0] M_MAX  = MIN_W'(MAX_MINS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [MIN_W-1:0] r_mins, w_mins_nxt;
  logic [SEC_W-1:0] r_secs, w_secs_nxt;
  logic [PW-1:0]    r_presc;
  logic             r_tick_pend, w_pend_nxt;
  logic             r_expired, w_exp_nxt;

  logic             w_tick, w_do_tick, w_bonus_act, w_warn;
  logic [MIN_W-1:0] w_load_mins;
  logic [SEC_W-1:0] w_load_secs, w_bonus_secs;
  logic [SEC_W:0]   w_sum;
  logic [31:0]      w_total;
  logic [7:0]       w_m8, w_s8;

  assign w_load_mins  = (bus.load_mins_i > M_MAX) ? M_MAX : bus.load_mins_i;
  assign w_load_secs  = (bus.load_secs_i > C59) ? C59 : bus.load_secs_i;
  assign w_bonus_secs = (bus.bonus_secs_i > C59) ? C59 : bus.bonus_secs_i;
  assign w_sum        = {1'b0, r_secs} + {1'b0, w_bonus_secs};

  assign w_tick      = (r_state == S_RUN) && (r_presc == P_LAST);
  assign w_bonus_act = bus.bonus_i && (r_state != S_EXPIRED);
  // A tick swallowed by a bonus cycle is replayed from tick_pend while still running.
  assign w_do_tick   = (w_tick || r_tick_pend) && (r_state == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mins      <= '0;
      r_secs      <= '0;
      r_tick_pend <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mins      <= w_mins_nxt;
      r_secs      <= w_secs_nxt;
      r_tick_pend <= w_pend_nxt;
      r_expired   <= w_exp_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (bus.load_i) begin
      r_presc <= '0;
    end else if (r_state == S_RUN) begin
      r_presc <= (r_presc == P_LAST) ? '0 : r_presc + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mins_nxt  = r_mins;
    w_secs_nxt  = r_secs;
    w_pend_nxt  = r_tick_pend;
    w_exp_nxt   = 1'b0;
    if (bus.load_i) begin
      w_mins_nxt  = w_load_mins;
      w_secs_nxt  = w_load_secs;
      w_state_nxt = S_IDLE;
      w_pend_nxt  = 1'b0;
    end else if (w_bonus_act) begin
      if (w_sum >= C60) begin
        if (r_mins >= M_MAX) begin
          w_mins_nxt = M_MAX;
          w_secs_nxt = C59;
        end else begin
          w_mins_nxt = r_mins + 1'b1;
          w_secs_nxt = SEC_W'(w_sum - C60);
        end
      end else begin
        w_secs_nxt = w_sum[SEC_W-1:0];
      end
      if (w_tick) w_pend_nxt = 1'b1;
    end else if (w_do_tick) begin
      w_pend_nxt = 1'b0;
      if (r_secs != '0) begin
        w_secs_nxt = r_secs - 1'b1;
      end else begin
        w_mins_nxt = r_mins - 1'b1;
        w_secs_nxt = C59;
      end
      if ((r_mins == '0) && (r_secs == SEC_W'(1))) begin
        w_state_nxt = S_EXPIRED;
        w_exp_nxt   = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start_i && ((r_mins != '0) || (r_secs != '0))) w_state_nxt = S_RUN;
        S_RUN:   if (bus.pause_i) w_state_nxt = S_PAUSE;
        S_PAUSE: if (bus.start_i) w_state_nxt = S_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign w_total = 32'(r_mins) * 32'd60 + 32'(r_secs);
  assign w_warn  = ((r_state == S_RUN) || (r_state == S_PAUSE)) &&
                   (w_total != 32'd0) && (w_total <= 32'(WARN_SECS));

  // Both fields are at most 99, so an 8-bit view is enough for the BCD split.
  assign w_m8 = 8'(r_mins);
  assign w_s8 = 8'(r_secs);

  assign bus.timer_mins   = r_mins;
  assign bus.timer_secs   = r_secs;
  assign bus.hex_digits_o = {4'(w_m8 / 8'd10), 4'(w_m8 % 8'd10),
                             4'(w_s8 / 8'd10), 4'(w_s8 % 8'd10)};
  assign bus.state_o      = r_state;
  assign bus.expired_o    = r_expired;
  assign bus.warn_o       = w_warn;

`ifdef QUIZ_TIMER_WARN_BLINK_EN
  localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2 - 1);
  logic r_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blank <= 1'b0;
    end else if (!w_warn) begin
      r_blank <= 1'b0;
    end else if ((r_state == S_RUN) && ((r_presc == P_HALF) || (r_presc == P_LAST))) begin
      r_blank <= ~r_blank;
    end
  end

  assign bus.blank_o = r_blank;
`else
  assign bus.blank_o = 1'b0;
`endif

endmodule

// File: tb/tb_quiz_countdown_timer.sv
// tb/tb_quiz_countdown_timer.sv - bench for quiz_countdown_timer (TICK_DIV=4)
// Reference keeps remaining time as a total-seconds count.
module tb_quiz_countdown_timer;
  localparam int TD   = 4;
  localparam int MAXM = 59;
  localparam int WARN = 10;
  localparam int MAXT = MAXM * 60 + 59;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quiz_countdown_timer_if #(.MIN_W(6), .SEC_W(6)) bus ();

  quiz_countdown_timer #(
    .TICK_DIV(TD), .MIN_W(6), .SEC_W(6), .MAX_MINS(MAXM), .WARN_SECS(WARN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int m_rem, m_state, m_presc;
  bit m_pend, m_exp;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_state = 0; m_presc = 0; m_pend = 0; m_exp = 0;
  endtask

  task automatic model_step();
    bit tick;
    tick = (m_state == 1) && (m_presc == TD - 1);
    m_exp = 0;
    if (bus.load_i) m_presc = 0;
    else if (m_state == 1) m_presc = (m_presc + 1) % TD;
    if (bus.load_i) begin
      m_rem   = imin(int'(bus.load_mins_i), MAXM) * 60 + imin(int'(bus.load_secs_i), 59);
      m_state = 0;
      m_pend  = 0;
    end else if (bus.bonus_i && m_state != 3) begin
      m_rem = imin(m_rem + imin(int'(bus.bonus_secs_i), 59), MAXT);
      if (tick) m_pend = 1;
    end else if ((tick || m_pend) && m_state == 1) begin
      m_pend = 0;
      m_rem  = m_rem - 1;
      if (m_rem == 0) begin
        m_state = 3;
        m_exp   = 1;
      end
    end else if (m_state == 0 && bus.start_i && m_rem != 0) m_state = 1;
    else if (m_state == 1 && bus.pause_i) m_state = 2;
    else if (m_state == 2 && bus.start_i) m_state = 1;
  endtask

  task automatic check_all();
    int mm, ss;
    logic [15:0] hx;
    mm = m_rem / 60;
    ss = m_rem % 60;
    hx = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    chk("timer_mins", 32'(bus.timer_mins), mm);
    chk("timer_secs", 32'(bus.timer_secs), ss);
    chk("hex_digits", 32'(bus.hex_digits_o), 32'(hx));
    chk("state", 32'(bus.state_o), m_state);
    chk("expired", 32'(bus.expired_o), 32'(m_exp));
    chk("warn", 32'(bus.warn_o), 32'((m_state == 1 || m_state == 2) && m_rem > 0 && m_rem <= WARN));
`ifndef QUIZ_TIMER_WARN_BLINK_EN
    chk("blank", 32'(bus.blank_o), 0);
`endif
  endtask

  task automatic idle_in();
    bus.load_i = 0; bus.start_i = 0; bus.pause_i = 0; bus.bonus_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    idle_in();
  endtask

  task automatic do_load(input int mm, input int ss);
    bus.load_i = 1; bus.load_mins_i = 6'(mm); bus.load_secs_i = 6'(ss);
    cyc();
  endtask

  task automatic do_start();
    bus.start_i = 1;
    cyc();
  endtask

  initial begin
    int exp_cnt;
    idle_in();
    bus.load_mins_i = '0; bus.load_secs_i = '0; bus.bonus_secs_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // load 01:02 and count down
    do_load(1, 2);
    do_start();
    repeat (4) cyc();
    chk("t1_0101_mins", 32'(bus.timer_mins), 1);
    chk("t1_0101_secs", 32'(bus.timer_secs), 1);
    repeat (8) cyc();
    chk("t1_hex_0059", 32'(bus.hex_digits_o), 32'h0059);

    // expiry pulse, start ignored, load returns to idle
    do_load(0, 2);
    do_start();
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.expired_o === 1'b1) exp_cnt++;
    end
    chk("t2_state_expired", 32'(bus.state_o), 3);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.expired_o === 1'b1) exp_cnt++;
    end
    chk("t2_pulse_count", exp_cnt, 1);
    do_start();
    chk("t2_start_ignored", 32'(bus.state_o), 3);
    do_load(0, 0);
    chk("t2_load_idle", 32'(bus.state_o), 0);
    do_start();
    chk("t2_start_zero_idle", 32'(bus.state_o), 0);

    // pause and resume
    do_load(0, 5);
    do_start();
    cyc();
    bus.pause_i = 1;
    cyc();
    repeat (20) cyc();
    chk("t3_paused_secs", 32'(bus.timer_secs), 5);
    chk("t3_paused_state", 32'(bus.state_o), 2);
    bus.start_i = 1; bus.pause_i = 1;
    cyc();
    chk("t3_start_wins_pause", 32'(bus.state_o), 1);
    cyc();
    chk("t3_resume_1cyc", 32'(bus.timer_secs), 5);
    cyc();
    chk("t3_resume_2cyc", 32'(bus.timer_secs), 4);

    // bonus saturation and clamp
    do_load(59, 50);
    bus.bonus_i = 1; bus.bonus_secs_i = 6'd30;
    cyc();
    chk("t4_sat", {16'(bus.timer_mins), 16'(bus.timer_secs)}, {16'd59, 16'd59});
    do_load(0, 10);
    bus.bonus_i = 1; bus.bonus_secs_i = 6'd63;
    cyc();
    chk("t4_clamp", {16'(bus.timer_mins), 16'(bus.timer_secs)}, {16'd1, 16'd9});

    // bonus on tick cycle -> pending tick
    do_load(0, 20);
    do_start();
    repeat (3) cyc();
    bus.bonus_i = 1; bus.bonus_secs_i = 6'd5;
    cyc();
    chk("t5_bonus_secs", 32'(bus.timer_secs), 25);
    cyc();
    chk("t5_pending_secs", 32'(bus.timer_secs), 24);

    // warning window
    do_load(0, 12);
    do_start();
    repeat (7) cyc();
    chk("t6_warn_at_11", 32'(bus.warn_o), 0);
    cyc();
    chk("t6_warn_at_10", 32'(bus.warn_o), 1);
    for (int i = 0; i < 80 && bus.state_o !== 2'd3; i++) cyc();
    chk("t6_expired_bound", 32'(bus.state_o), 3);
    chk("t6_warn_off", 32'(bus.warn_o), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.load_i       = ($urandom_range(0, 39) == 0);
      bus.load_mins_i  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      bus.load_secs_i  = 6'($urandom_range(0, 63));
      bus.start_i      = ($urandom_range(0, 5) == 0);
      bus.pause_i      = ($urandom_range(0, 11) == 0);
      bus.bonus_i      = ($urandom_range(0, 15) == 0);
      bus.bonus_secs_i = 6'($urandom_range(0, 63));
      cyc();
    end

    // asynchronous reset mid-run
    do_load(1, 0);
    do_start();
    repeat (6) cyc();
    @(posedge clk);
    model_step();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #3;
    rst = 1'b0;
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
